// File: rtl/effect_select_if.sv
// Video stream bundle for effect_select: raw pixel path, NUM_CH effect paths and the
// registered output path, each with data/hsync/vsync/VDE.
interface effect_select_if #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 3
);
  logic [DATA_WIDTH-1:0]        i_vid_data;
  logic                         i_vid_hsync;
  logic                         i_vid_vsync;
  logic                         i_vid_VDE;
  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_data;
  logic [NUM_CH-1:0]            i_ch_hsync;
  logic [NUM_CH-1:0]            i_ch_vsync;
  logic [NUM_CH-1:0]            i_ch_VDE;
  logic [DATA_WIDTH-1:0]        o_vid_data;
  logic                         o_vid_hsync;
  logic                         o_vid_vsync;
  logic                         o_vid_VDE;

  modport master (
    output i_vid_data, i_vid_hsync, i_vid_vsync, i_vid_VDE,
    output i_ch_data, i_ch_hsync, i_ch_vsync, i_ch_VDE,
    input  o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE
  );

  modport slave (
    input  i_vid_data, i_vid_hsync, i_vid_vsync, i_vid_VDE,
    input  i_ch_data, i_ch_hsync, i_ch_vsync, i_ch_VDE,
    output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE
  );
endinterface

// File: rtl/effect_select.sv
// Frame-synchronous video effect selector: bypass or one of NUM_CH effect streams, chosen by
// switches or debounced buttons. Define FRAME_SYNC_SWITCH_EN to defer switching to vsync rises.
module effect_select #(
  parameter int DATA_WIDTH      = 24,
  parameter int NUM_CH          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             n_rst,
  effect_select_if.slave   vid,
  input  logic [3:0]       sw,
  input  logic [3:0]       btn,
  output logic [3:0]       led
);

  localparam int         CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [3:0] MAX_SEL = 4'(NUM_CH);

  logic [1:0] btn_press;
  logic [3:0] sw_q_reg;
  logic [3:0] req_sel_reg;
  logic [3:0] req_sel_next;
  logic [3:0] act_sel_reg;
  logic       change_pending;

  logic [DATA_WIDTH-1:0] mux_data;
  logic                  mux_hsync;
  logic                  mux_vsync;
  logic                  mux_vde;

  wire unused_btn = &{1'b0, btn[3:2]};

  // A press is the rising edge of the debounced level; any disagreement with the accepted
  // level must persist DEBOUNCE_CYCLES cycles before it is taken.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_reg;
    logic             sync2_reg;
    logic             acc_reg;
    logic             acc_prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        sync1_reg    <= 1'b0;
        sync2_reg    <= 1'b0;
        acc_reg      <= 1'b0;
        acc_prev_reg <= 1'b0;
        cnt_reg      <= '0;
      end else begin
        sync1_reg    <= btn[gi];
        sync2_reg    <= sync1_reg;
        acc_prev_reg <= acc_reg;
        if (sync2_reg == acc_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          acc_reg <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign btn_press[gi] = acc_reg & ~acc_prev_reg;
  end

  always_comb begin
    req_sel_next = req_sel_reg;
    if (sw != sw_q_reg) begin
      req_sel_next = (sw > MAX_SEL) ? 4'd0 : sw;
    end else if (btn_press[1]) begin
      req_sel_next = 4'd0;
    end else if (btn_press[0]) begin
      req_sel_next = (req_sel_reg == MAX_SEL) ? 4'd0 : req_sel_reg + 4'd1;
    end
  end

`ifdef FRAME_SYNC_SWITCH_EN
  logic vsync_q_reg;
  logic frame_edge;

  // The boundary always comes from the raw stream, independent of the active source.
  assign frame_edge     = vid.i_vid_vsync & ~vsync_q_reg;
  assign change_pending = (req_sel_reg != act_sel_reg);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vsync_q_reg <= 1'b0;
      act_sel_reg <= 4'd0;
    end else begin
      vsync_q_reg <= vid.i_vid_vsync;
      if (frame_edge) begin
        act_sel_reg <= req_sel_reg;
      end
    end
  end
`else
  assign change_pending = 1'b0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_sel_reg <= 4'd0;
    end else begin
      act_sel_reg <= req_sel_reg;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sw_q_reg    <= 4'd0;
      req_sel_reg <= 4'd0;
    end else begin
      sw_q_reg    <= sw;
      req_sel_reg <= req_sel_next;
    end
  end

  // Unmatched select values fall back to bypass.
  always_comb begin
    mux_data  = vid.i_vid_data;
    mux_hsync = vid.i_vid_hsync;
    mux_vsync = vid.i_vid_vsync;
    mux_vde   = vid.i_vid_VDE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act_sel_reg == 4'(i + 1)) begin
        mux_data  = vid.i_ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        mux_hsync = vid.i_ch_hsync[i];
        mux_vsync = vid.i_ch_vsync[i];
        mux_vde   = vid.i_ch_VDE[i];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vid.o_vid_data  <= '0;
      vid.o_vid_hsync <= 1'b0;
      vid.o_vid_vsync <= 1'b0;
      vid.o_vid_VDE   <= 1'b0;
      led             <= 4'd0;
    end else begin
      vid.o_vid_data  <= mux_data;
      vid.o_vid_hsync <= mux_hsync;
      vid.o_vid_vsync <= mux_vsync;
      vid.o_vid_VDE   <= mux_vde;
      led             <= {change_pending, act_sel_reg[2:0]};
    end
  end

endmodule

// File: doc/effect_select.md
# effect_select

Parametrised, frame-synchronous video effect selector for the vid_io pixel path. Takes the raw pixel stream plus NUM_CH effect-processed streams, each with its own data/hsync/vsync/VDE, and drives one registered output stream. Selection comes from the switches or from a debounced button that cycles modes. A new selection takes effect only at a frame boundary, so there is no mid-frame tearing. Sits between the capture pipeline and the video output, replacing direct per-effect muxing.

## Interface
- DATA_WIDTH, 24, pixel width (8 bits each R, G, B)
- NUM_CH, 3, number of effect channels (1..15); select 0 = bypass, k = channel k-1
- DEBOUNCE_CYCLES, 1000000, cycles a button level must be stable before it is accepted
- clk  in  1  pixel clock
- n_rst  in  1  asynchronous active-low reset
- i_vid_data  in  DATA_WIDTH  raw pixel (bypass source)
- i_vid_hsync / i_vid_vsync / i_vid_VDE  in  1 each  raw sync/valid
- i_ch_data  in  NUM_CH*DATA_WIDTH  packed effect pixels; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- i_ch_hsync / i_ch_vsync / i_ch_VDE  in  NUM_CH each  effect sync/valid; bit c = channel c
- o_vid_data  out  DATA_WIDTH  selected pixel, registered
- o_vid_hsync / o_vid_vsync / o_vid_VDE  out  1 each  selected sync/valid, registered
- sw  in  4  direct mode select
- btn  in  4  btn[0] = next mode, btn[1] = force bypass; btn[3:2] unused
- led  out  4  led[2:0] = active select (low 3 bits); led[3] = change pending

## Operation
- The block holds two 4-bit registers: req_sel (requested) and act_sel (active). Both reset to 0.
- sw handling: sw is registered each cycle into sw_q. When sw != sw_q, req_sel <= (sw > NUM_CH) ? 0 : sw.
- Button handling: each btn[1:0] bit passes through a 2-flop synchroniser, then a debounce counter. The counter resets on any level change and accepts the level after DEBOUNCE_CYCLES stable cycles. A press is the rising edge of the accepted level.
- btn[0] press: req_sel <= (req_sel == NUM_CH) ? 0 : req_sel + 1.
- btn[1] press: req_sel <= 0.
- Priority when events coincide: sw change > btn[1] > btn[0].
- Frame boundary is the rising edge of i_vid_vsync: registered previous value is 0 and current value is 1. On a boundary cycle act_sel <= req_sel. The boundary edge always comes from the raw input, whatever is selected.
- Output mux:
  - act_sel == 0 selects the i_vid_* inputs.
  - act_sel == k selects channel k-1.
  - The selected data and syncs are registered into o_vid_*.
- LEDs are registered: led[2:0] = act_sel[2:0], led[3] = (req_sel != act_sel).

## Timing
- Reset values: o_vid_data = 0, o_vid_hsync = o_vid_vsync = o_vid_VDE = 0, led = 0, req_sel = act_sel = 0, debounce state idle (accepted level 0).
- Latency is 1 cycle from the selected inputs to o_vid_*. Latency is identical for data and syncs, so stream alignment is preserved.
- sw change: req_sel updates 1 cycle after sw settles (sw_q compare).
- Button press: req_sel updates 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the button level change.
- Boundary edge at clock edge N:
  - act_sel changes at edge N.
  - o_vid_* at edge N+1 carry the new source.
  - led updates at edge N+1.
- A request made on the boundary cycle itself is not applied until the next boundary.
- A request reverted before a boundary (req_sel returns to act_sel) produces no change.
- Reset mid-frame: all state clears immediately, and the output shows bypass from the first clock after release.

## Configuration
- FRAME_SYNC_SWITCH_EN defined: act_sel loads only on i_vid_vsync rising edges, as described above.
- FRAME_SYNC_SWITCH_EN undefined: act_sel <= req_sel every cycle. Switching is immediate (1 cycle after req_sel), and led[3] is constant 0.

## Test plan
- Reset, NUM_CH=3, sw=0, drive distinct constant pixels per source: o_vid_data = raw pixel, led = 4'b0000; all outputs were 0 during reset.
- sw=2 mid-frame: led = 4'b1000 until the next i_vid_vsync rise. 1 cycle after that edge o_vid_data = channel-1 pixel and led = 4'b0010. Earlier output remains raw.
- sw=7 (> NUM_CH): req_sel = 0. After the boundary, output = raw stream and led = 4'b0000.
- btn[0] pulses of 50 cycles with DEBOUNCE_CYCLES=100 are ignored. Four accepted presses from select 0 step req_sel 1, 2, 3, 0 (wrap); each is applied at the following vsync edge.
- sw change and accepted btn[1] press on the same cycle: sw wins. Then an n_rst pulse mid-frame: outputs are 0 during reset and bypass after release.
- With FRAME_SYNC_SWITCH_EN undefined, sw=3: o_vid_data = channel-2 pixel 3 cycles after the sw change (sw_q, req_sel, output register), with no wait for vsync.
